// File: rtl/fft_sink_buf.sv
`default_nettype none
// ============================================================================
// Module   : fft_sink_buf
// Desc     : Two-bank ping-pong buffer that collects FFT output blocks and
//            replays them in arrival order over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module fft_sink_buf #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_LDN    = 11
) (
   input  logic                  clk_sys,
   input  logic                  rst_sys_n,
   input  logic                  block_sync_i,
   input  logic                  data_val_i,
   input  logic [DATA_WIDTH-1:0] data_real_i,
   input  logic [DATA_WIDTH-1:0] data_imag_i,
   input  logic [3:0]            ldn_rg_i,
   input  logic                  data_rdy_i,
   output logic                  block_sync_o,
   output logic                  data_val_o,
   output logic [DATA_WIDTH-1:0] data_real_o,
   output logic [DATA_WIDTH-1:0] data_imag_o,
   output logic [3:0]            ldn_rg_o,
   output logic                  overflow_o,
   output logic                  err_o
);

   localparam int                 c_depth    = 1 << MAX_LDN;
   localparam logic [MAX_LDN-1:0] c_addr_one = 1;
   localparam logic [MAX_LDN-1:0] c_ones     = '1;
   localparam logic [3:0]         c_max_ldn  = 4'(MAX_LDN);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_DROP = 2'd2
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_SEND = 1'b1
   } rd_state_t;

   // Both banks live in one array; the bank select is the address MSB.
   logic [2*DATA_WIDTH-1:0] r_mem [0:2*c_depth-1];

   wr_state_t          r_wr_state, w_wr_state_nxt;
   logic [MAX_LDN-1:0] r_wr_cnt, w_wr_cnt_nxt;
   logic [3:0]         r_wr_ldn, w_wr_ldn_nxt;
   logic               r_wr_bank, w_wr_bank_nxt;
   logic               w_wr_en;
   logic [MAX_LDN-1:0] w_wr_addr;
   logic [MAX_LDN-1:0] w_wr_last;
   logic [1:0]         w_full_set;
   logic               w_err;
   logic               w_ovf;
   logic               w_start;
   logic               w_ldn_ok;

   rd_state_t          r_rd_state, w_rd_state_nxt;
   logic [MAX_LDN-1:0] r_rd_addr, w_rd_addr_nxt;
   logic               r_rd_bank, w_rd_bank_nxt;
   logic [MAX_LDN-1:0] w_rd_last;
   logic               w_load;
   logic               w_issue;
   logic [1:0]         w_full_clr;

   logic [1:0]         r_full;
   logic [3:0]         r_bank_ldn [0:1];
   logic               r_out_last;
   logic               r_out_bank;

   assign w_start   = block_sync_i & data_val_i;
   assign w_ldn_ok  = (ldn_rg_i >= 4'd2) && (ldn_rg_i <= c_max_ldn);
   assign w_wr_last = ~(c_ones << r_wr_ldn);
   assign w_wr_addr = w_start ? '0 : r_wr_cnt;

   // ------------------------------------------------------------------ write
   always_comb begin
      w_wr_state_nxt = r_wr_state;
      w_wr_cnt_nxt   = r_wr_cnt;
      w_wr_ldn_nxt   = r_wr_ldn;
      w_wr_bank_nxt  = r_wr_bank;
      w_wr_en        = 1'b0;
      w_full_set     = 2'b00;
      w_err          = 1'b0;
      w_ovf          = 1'b0;
      if (w_start) begin
         // A sync mid-fill truncates the current block but reuses its bank.
         w_err        = (r_wr_state == W_FILL);
         w_wr_ldn_nxt = ldn_rg_i;
         w_wr_cnt_nxt = c_addr_one;
         if (!w_ldn_ok) begin
            w_err          = 1'b1;
            w_wr_state_nxt = W_IDLE;
         end else if (r_full[r_wr_bank]) begin
            w_ovf          = 1'b1;
            w_wr_state_nxt = W_DROP;
         end else begin
            w_wr_en        = 1'b1;
            w_wr_state_nxt = W_FILL;
         end
      end else if (data_val_i && (r_wr_state != W_IDLE)) begin
         w_wr_en      = (r_wr_state == W_FILL);
         w_wr_cnt_nxt = r_wr_cnt + c_addr_one;
         if (r_wr_cnt == w_wr_last) begin
            w_wr_state_nxt = W_IDLE;
            if (r_wr_state == W_FILL) begin
               w_full_set[r_wr_bank] = 1'b1;
               w_wr_bank_nxt         = ~r_wr_bank;
            end
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_wr_state <= W_IDLE;
         r_wr_cnt   <= '0;
         r_wr_ldn   <= '0;
         r_wr_bank  <= 1'b0;
         err_o      <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         r_wr_cnt   <= w_wr_cnt_nxt;
         r_wr_ldn   <= w_wr_ldn_nxt;
         r_wr_bank  <= w_wr_bank_nxt;
         err_o      <= w_err;
         overflow_o <= w_ovf;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (w_wr_en) begin
         r_mem[{r_wr_bank, w_wr_addr}] <= {data_real_i, data_imag_i};
      end
   end

   // Writer sets only a free bank and the reader clears only a full one.
   assign w_full_clr = {data_val_o & data_rdy_i & r_out_last & r_out_bank,
                        data_val_o & data_rdy_i & r_out_last & ~r_out_bank};

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_full        <= 2'b00;
         r_bank_ldn[0] <= '0;
         r_bank_ldn[1] <= '0;
      end else begin
         r_full <= (r_full | w_full_set) & ~w_full_clr;
         if (|w_full_set) begin
            r_bank_ldn[r_wr_bank] <= r_wr_ldn;
         end
      end
   end

   // ------------------------------------------------------------------- read
   assign w_rd_last = ~(c_ones << r_bank_ldn[r_rd_bank]);
   assign w_load    = ~data_val_o | data_rdy_i;

   always_comb begin
      w_rd_state_nxt = r_rd_state;
      w_rd_addr_nxt  = r_rd_addr;
      w_rd_bank_nxt  = r_rd_bank;
      w_issue        = 1'b0;
      case (r_rd_state)
         R_IDLE: begin
            if (r_full[r_rd_bank]) begin
               w_rd_state_nxt = R_SEND;
            end
         end
         R_SEND: begin
            if (w_load) begin
               w_issue = 1'b1;
               if (r_rd_addr == w_rd_last) begin
                  // Chain straight into the next bank when it is already full.
                  w_rd_addr_nxt = '0;
                  w_rd_bank_nxt = ~r_rd_bank;
                  if (!r_full[~r_rd_bank]) begin
                     w_rd_state_nxt = R_IDLE;
                  end
               end else begin
                  w_rd_addr_nxt = r_rd_addr + c_addr_one;
               end
            end
         end
         default: w_rd_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_rd_state <= R_IDLE;
         r_rd_addr  <= '0;
         r_rd_bank  <= 1'b0;
      end else begin
         r_rd_state <= w_rd_state_nxt;
         r_rd_addr  <= w_rd_addr_nxt;
         r_rd_bank  <= w_rd_bank_nxt;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         data_val_o   <= 1'b0;
         block_sync_o <= 1'b0;
         data_real_o  <= '0;
         data_imag_o  <= '0;
         ldn_rg_o     <= '0;
         r_out_last   <= 1'b0;
         r_out_bank   <= 1'b0;
      end else if (w_issue) begin
         data_val_o   <= 1'b1;
         block_sync_o <= (r_rd_addr == '0);
         data_real_o  <= r_mem[{r_rd_bank, r_rd_addr}][2*DATA_WIDTH-1:DATA_WIDTH];
         data_imag_o  <= r_mem[{r_rd_bank, r_rd_addr}][DATA_WIDTH-1:0];
         ldn_rg_o     <= r_bank_ldn[r_rd_bank];
         r_out_last   <= (r_rd_addr == w_rd_last);
         r_out_bank   <= r_rd_bank;
      end else if (data_rdy_i) begin
         data_val_o   <= 1'b0;
         block_sync_o <= 1'b0;
         r_out_last   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_sink_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_sink_buf
// Desc     : Directed self-checking bench for fft_sink_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_sink_buf;

   localparam int DW = 16;

   logic          clk_sys      = 1'b0;
   logic          rst_sys_n    = 1'b0;
   logic          block_sync_i = 1'b0;
   logic          data_val_i   = 1'b0;
   logic [DW-1:0] data_real_i  = '0;
   logic [DW-1:0] data_imag_i  = '0;
   logic [3:0]    ldn_rg_i     = '0;
   logic          data_rdy_i   = 1'b0;
   logic          block_sync_o;
   logic          data_val_o;
   logic [DW-1:0] data_real_o;
   logic [DW-1:0] data_imag_o;
   logic [3:0]    ldn_rg_o;
   logic          overflow_o;
   logic          err_o;

   fft_sink_buf #(.DATA_WIDTH(DW), .MAX_LDN(11)) u_dut (
      .clk_sys      (clk_sys),
      .rst_sys_n    (rst_sys_n),
      .block_sync_i (block_sync_i),
      .data_val_i   (data_val_i),
      .data_real_i  (data_real_i),
      .data_imag_i  (data_imag_i),
      .ldn_rg_i     (ldn_rg_i),
      .data_rdy_i   (data_rdy_i),
      .block_sync_o (block_sync_o),
      .data_val_o   (data_val_o),
      .data_real_o  (data_real_o),
      .data_imag_o  (data_imag_o),
      .ldn_rg_o     (ldn_rg_o),
      .overflow_o   (overflow_o),
      .err_o        (err_o)
   );

   always #5 clk_sys = ~clk_sys;

   int n_vec   = 0;
   int n_err   = 0;
   int cyc     = 0;
   int err_cnt = 0;
   int ovf_cnt = 0;
   int last_wr = 0;
   int q_re[$];
   int q_im[$];
   int q_sync[$];
   int q_ldn[$];
   int q_cyc[$];

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Accepted transfers and status pulses are collected mid-cycle.
   always @(negedge clk_sys) begin
      if (err_o)      err_cnt++;
      if (overflow_o) ovf_cnt++;
      if (data_val_o && data_rdy_i) begin
         q_re.push_back(int'($signed(data_real_o)));
         q_im.push_back(int'($signed(data_imag_o)));
         q_sync.push_back(int'(block_sync_o));
         q_ldn.push_back(int'(ldn_rg_o));
         q_cyc.push_back(cyc);
      end
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic drive(input bit s, input bit v, input int re, input int im, input int ldn);
      @(posedge clk_sys);
      #1;
      block_sync_i = s;
      data_val_i   = v;
      data_real_i  = DW'(re);
      data_imag_i  = DW'(im);
      ldn_rg_i     = 4'(ldn);
   endtask

   task automatic send_block(input int n, input int ldn, input int base);
      for (int k = 0; k < n; k++) drive(k == 0, 1'b1, base + k, -(base + k), ldn);
   endtask

   // Drops the inputs; last_wr is the cycle of the edge that wrote the last sample.
   task automatic go_idle();
      drive(1'b0, 1'b0, 0, 0, 0);
      last_wr = cyc;
   endtask

   task automatic check_out(input string tag, input int start, input int n, input int base, input int ldn);
      for (int k = 0; k < n; k++) begin
         if (start + k < q_re.size()) begin
            check_val({tag, "_re"},   q_re[start + k],   base + k);
            check_val({tag, "_im"},   q_im[start + k],   -(base + k));
            check_val({tag, "_sync"}, q_sync[start + k], (k == 0) ? 1 : 0);
            check_val({tag, "_ldn"},  q_ldn[start + k],  ldn);
         end
      end
   endtask

   task automatic wait_for_re(input int v, output bit seen);
      int t;
      t = 0;
      while (!(data_val_o && ($signed(data_real_o) == v)) && t < 60) begin
         wait_cyc(1);
         t++;
      end
      seen = (t < 60);
   endtask

   initial begin
      int s;
      int e0;
      int o0;
      bit seen;

      // Reset state
      @(negedge clk_sys);
      check_val("rst_val",  int'(data_val_o),   0);
      check_val("rst_sync", int'(block_sync_o), 0);
      check_val("rst_re",   int'(data_real_o),  0);
      check_val("rst_im",   int'(data_imag_o),  0);
      check_val("rst_ldn",  int'(ldn_rg_o),     0);
      check_val("rst_ovf",  int'(overflow_o),   0);
      check_val("rst_err",  int'(err_o),        0);
      wait_cyc(3);
      rst_sys_n = 1'b1;
      wait_cyc(2);

      // Basic block, full rate
      data_rdy_i = 1'b1;
      s = q_re.size();
      send_block(8, 3, 0);
      go_idle();
      wait_cyc(15);
      check_val("t1_cnt", q_re.size() - s, 8);
      check_out("t1", s, 8, 0, 3);
      if (q_cyc.size() >= s + 8) begin
         check_val("t1_lat", q_cyc[s] - last_wr, 2);
         check_val("t1_span", q_cyc[s + 7] - q_cyc[s], 7);
      end

      // Backpressure stall at k=3
      s = q_re.size();
      send_block(8, 3, 0);
      go_idle();
      wait_for_re(3, seen);
      check_val("t2_k3_seen", int'(seen), 1);
      data_rdy_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         check_val("t2_hold_val",  int'(data_val_o), 1);
         check_val("t2_hold_re",   int'($signed(data_real_o)), 3);
         check_val("t2_hold_im",   int'($signed(data_imag_o)), -3);
         check_val("t2_hold_sync", int'(block_sync_o), 0);
         wait_cyc(1);
      end
      data_rdy_i = 1'b1;
      wait_cyc(15);
      check_val("t2_cnt", q_re.size() - s, 8);
      check_out("t2", s, 8, 0, 3);

      // Truncated block followed by a complete one
      s  = q_re.size();
      e0 = err_cnt;
      send_block(5, 3, 100);
      send_block(8, 3, 200);
      go_idle();
      wait_cyc(15);
      check_val("t3_err", err_cnt - e0, 1);
      check_val("t3_cnt", q_re.size() - s, 8);
      check_out("t3", s, 8, 200, 3);

      // Overflow with both banks held
      data_rdy_i = 1'b0;
      s  = q_re.size();
      e0 = err_cnt;
      o0 = ovf_cnt;
      send_block(8, 3, 300);
      send_block(8, 3, 400);
      send_block(8, 3, 500);
      go_idle();
      wait_cyc(5);
      check_val("t4_ovf", ovf_cnt - o0, 1);
      check_val("t4_err", err_cnt - e0, 0);
      data_rdy_i = 1'b1;
      wait_cyc(30);
      check_val("t4_cnt", q_re.size() - s, 16);
      check_out("t4a", s, 8, 300, 3);
      check_out("t4b", s + 8, 8, 400, 3);
      if (q_cyc.size() >= s + 16) begin
         check_val("t4_nogap", q_cyc[s + 8] - q_cyc[s + 7], 1);
      end

      // Illegal ldn above and below range, then smallest legal block
      s  = q_re.size();
      e0 = err_cnt;
      send_block(8, 12, 600);
      go_idle();
      send_block(4, 1, 650);
      go_idle();
      wait_cyc(10);
      check_val("t5_err", err_cnt - e0, 2);
      check_val("t5_none", q_re.size() - s, 0);
      send_block(4, 2, 700);
      go_idle();
      wait_cyc(10);
      check_val("t5_cnt", q_re.size() - s, 4);
      check_out("t5", s, 4, 700, 2);
      if (q_cyc.size() >= s + 1) begin
         check_val("t5_lat", q_cyc[s] - last_wr, 2);
      end

      // Reset during readout
      send_block(8, 3, 800);
      go_idle();
      wait_for_re(804, seen);
      check_val("t6_k4_seen", int'(seen), 1);
      rst_sys_n = 1'b0;
      @(negedge clk_sys);
      check_val("t6_val",  int'(data_val_o),   0);
      check_val("t6_sync", int'(block_sync_o), 0);
      check_val("t6_re",   int'(data_real_o),  0);
      check_val("t6_im",   int'(data_imag_o),  0);
      check_val("t6_ldn",  int'(ldn_rg_o),     0);
      wait_cyc(2);
      rst_sys_n = 1'b1;
      s = q_re.size();
      wait_cyc(10);
      check_val("t6_quiet", q_re.size() - s, 0);
      send_block(4, 2, 900);
      go_idle();
      wait_cyc(10);
      check_val("t6_cnt", q_re.size() - s, 4);
      check_out("t6", s, 4, 900, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
